// File: rtl/axi_sram_responder_if.sv
// rtl/axi_sram_responder_if.sv - AXI3 bus bundle between the cache-side master and the SRAM responder
interface axi_sram_responder_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_sram_responder.sv
// rtl/axi_sram_responder.sv - AXI3 slave answering single and burst accesses from an internal word memory
module axi_sram_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int RD_DELAY  = 0
) (
  input logic                  clk,
  input logic                  rstn,
  axi_sram_responder_if.slave  axi
);
  localparam int IDX = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_RESP} state_e;

  state_e      state_q;
  logic [31:0] mem [MEM_WORDS];

  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic        err_q;
  logic [3:0]  dly_q;

  logic        wready_q;
  logic        rvalid_q;
  logic        rlast_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [3:0]  rid_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic [3:0]  bid_q;

  logic [31:0] beat_addr_d;
  logic        bad_w;
  logic        ar_bad;
  logic        wlast_bad;
  logic        aw_hs;
  logic        ar_hs;
  logic        mem_we;

  function automatic logic [IDX-1:0] word_idx(input logic [31:0] a);
    return a[IDX+1:2];
  endfunction

  // Unsupported bursts still run their full beat count, only the response and data change.
  assign bad_w       = burst_q[1] | (size_q > 3'd2);
  assign ar_bad      = axi.arburst[1] | (axi.arsize > 3'd2);
  assign beat_addr_d = (burst_q == 2'b01) ? addr_q + (32'd1 << size_q) : addr_q;
  assign wlast_bad   = axi.wlast != (cnt_q == len_q);

  // Writes take priority, so AR is held off whenever AW is pending.
  assign axi.awready = rstn && (state_q == IDLE);
  assign axi.arready = rstn && (state_q == IDLE) && !axi.awvalid;
  assign aw_hs       = (state_q == IDLE) && axi.awvalid;
  assign ar_hs       = (state_q == IDLE) && axi.arvalid && !axi.awvalid;
  assign mem_we      = wready_q && axi.wvalid && !bad_w;

  assign axi.wready = wready_q;
  assign axi.rvalid = rvalid_q;
  assign axi.rlast  = rlast_q;
  assign axi.rdata  = rdata_q;
  assign axi.rresp  = rresp_q;
  assign axi.rid    = rid_q;
  assign axi.bvalid = bvalid_q;
  assign axi.bresp  = bresp_q;
  assign axi.bid    = bid_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (axi.wstrb[i]) mem[word_idx(addr_q)][8*i +: 8] <= axi.wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      dly_q    <= '0;
      wready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rid_q    <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      bid_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (aw_hs) begin
            id_q     <= axi.awid;
            addr_q   <= axi.awaddr;
            len_q    <= axi.awlen;
            size_q   <= axi.awsize;
            burst_q  <= axi.awburst;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            wready_q <= 1'b1;
            state_q  <= WR_DATA;
          end else if (ar_hs) begin
            id_q    <= axi.arid;
            addr_q  <= axi.araddr;
            len_q   <= axi.arlen;
            size_q  <= axi.arsize;
            burst_q <= axi.arburst;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rid_q   <= axi.arid;
            rresp_q <= ar_bad ? 2'b10 : 2'b00;
            rlast_q <= (axi.arlen == 8'd0);
            if (RD_DELAY > 0) begin
              dly_q   <= '0;
              state_q <= RD_WAIT;
            end else begin
              rvalid_q <= 1'b1;
              rdata_q  <= ar_bad ? 32'd0 : mem[word_idx(axi.araddr)];
              state_q  <= RD_BURST;
            end
          end
        end
        RD_WAIT: begin
          if (dly_q == 4'(RD_DELAY - 1)) begin
            rvalid_q <= 1'b1;
            rdata_q  <= bad_w ? 32'd0 : mem[word_idx(addr_q)];
            state_q  <= RD_BURST;
          end else begin
            dly_q <= dly_q + 4'd1;
          end
        end
        RD_BURST: begin
          if (axi.rready) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state_q  <= IDLE;
            end else begin
              cnt_q   <= cnt_q + 8'd1;
              addr_q  <= beat_addr_d;
              rdata_q <= bad_w ? 32'd0 : mem[word_idx(beat_addr_d)];
              rlast_q <= (cnt_q + 8'd1 == len_q);
            end
          end
        end
        WR_DATA: begin
          if (axi.wvalid) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= beat_addr_d;
            if (cnt_q == len_q) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= (bad_w | err_q | wlast_bad) ? 2'b10 : 2'b00;
              state_q  <= WR_RESP;
            end else begin
              err_q <= err_q | wlast_bad;
            end
          end
        end
        WR_RESP: begin
          if (axi.bready) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
